video_timing_gen: RTL and testbench

Parametrised raster timing and test-pattern source that drives video_lvds (DotClock domain) with HSync/VSync/DataEnable and RGB.
It generalises the fixed 1280x800 generator:
- separate front porch, sync and back porch per axis
- selectable sync polarity and colour width
- run/stop control and a frame-start strobe
- four run-time selectable test patterns, switched only at frame boundaries.

---
 rtl/vtg_pkg.sv | 22 ++
 rtl/vtg_pattern.sv | 74 +++++++
 rtl/video_timing_gen.sv | 147 ++++++++++++++
 tb/tb_video_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// Shared types and constants for the raster timing / test-pattern generator.
// Latency: n/a (types only).
// Backpressure: n/a.
package vtg_pkg;

    typedef enum logic [1:0] {
        PAT_XOR  = 2'd0,
        PAT_BARS = 2'd1,
        PAT_GRID = 2'd2,
        PAT_GRAY = 2'd3
    } pattern_t;

    // Bar colours as {R,G,B} full-scale flags; index 0 is the leftmost bar:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    localparam int BORDER_PX = 3;

endpackage

// File: rtl/vtg_pattern.sv
// Combinational test-pattern colour for one raster position.
// Latency: 0 cycles (registered by the parent).
// Backpressure: none.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int COLOR_W  = 6,
    parameter int CNT_W    = 12
) (
    input  logic [CNT_W-1:0]   x,
    input  logic [5:0]         y_lo,
    input  logic [5:0]         frame_lo,
    input  pattern_t           pattern,
    input  logic               border,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam logic [CNT_W-1:0]   BAR_W = CNT_W'(H_ACTIVE / 8);
    localparam logic [COLOR_W-1:0] FULL  = '1;
    localparam logic [COLOR_W-1:0] GRAY  = COLOR_W'(1) << (COLOR_W - 1);

    logic [5:0] v6;
    logic [5:0] r6;
    logic [5:0] g6;
    logic [5:0] b6;
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;

    always_comb begin
        // Parallax: both axes scroll with the frame counter, everything mod 64.
        v6      = (y_lo + frame_lo) ^ (x[5:0] + frame_lo);
        r6      = {v6[4:0], 1'b0};
        g6      = {v6[3:0], 2'b00};
        b6      = v6 + {v6[4:0], 1'b0};
        bar_idx = 3'(x / BAR_W);
        bar_rgb = BAR_RGB[bar_idx];
        red     = '0;
        green   = '0;
        blue    = '0;
        case (pattern)
            PAT_XOR: begin
                red   = COLOR_W'(r6) << (COLOR_W - 6);
                green = COLOR_W'(g6) << (COLOR_W - 6);
                blue  = COLOR_W'(b6) << (COLOR_W - 6);
            end
            PAT_BARS: begin
                red   = bar_rgb[2] ? FULL : '0;
                green = bar_rgb[1] ? FULL : '0;
                blue  = bar_rgb[0] ? FULL : '0;
            end
            PAT_GRID: begin
                if (x[4:0] == 5'd0 || y_lo[4:0] == 5'd0) begin
                    red   = FULL;
                    green = FULL;
                    blue  = FULL;
                end
            end
            default: begin
                red   = GRAY;
                green = GRAY;
                blue  = GRAY;
            end
        endcase
        if (border) begin
            red   = FULL;
            green = '0;
            blue  = '0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing (hs/vs/de) plus test-pattern RGB; VTG_BORDER_EN adds a red frame border.
// Latency: all outputs registered, one cycle behind the hc/vc counters.
// Backpressure: none; enable low parks the raster at origin with outputs idle.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 112,
    parameter int   V_ACTIVE = 800,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 3,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 6,
    parameter int   CNT_W    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   hc;
    logic [CNT_W-1:0]   vc;
    pattern_t           pat_act;
    pattern_t           pat_cur;
    logic               origin;
    logic               h_wrap;
    logic               v_wrap;
    logic               de_c;
    logic               hs_on;
    logic               vs_on;
    logic               border;
    logic [COLOR_W-1:0] pat_r;
    logic [COLOR_W-1:0] pat_g;
    logic [COLOR_W-1:0] pat_b;

    assign origin = (hc == '0) && (vc == '0) && enable;
    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);
    assign de_c   = (hc < H_ACT) && (vc < V_ACT);
    assign hs_on  = (hc >= HS_BEG) && (hc < HS_END);
    assign vs_on  = (vc >= VS_BEG) && (vc < VS_END);

    // The origin pixel already uses the freshly sampled pattern.
    assign pat_cur = origin ? pattern_t'(pattern_sel) : pat_act;

`ifdef VTG_BORDER_EN
    localparam logic [CNT_W-1:0] B_LO   = CNT_W'(BORDER_PX);
    localparam logic [CNT_W-1:0] BX_HI  = CNT_W'(H_ACTIVE - BORDER_PX);
    localparam logic [CNT_W-1:0] BY_HI  = CNT_W'(V_ACTIVE - BORDER_PX);
    assign border = (hc < B_LO) || (hc >= BX_HI) || (vc < B_LO) || (vc >= BY_HI);
`else
    assign border = 1'b0;
`endif

    vtg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .x        (hc),
        .y_lo     (vc[5:0]),
        .frame_lo (frame_cnt[5:0]),
        .pattern  (pat_cur),
        .border   (border),
        .red      (pat_r),
        .green    (pat_g),
        .blue     (pat_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc          <= '0;
            vc          <= '0;
            frame_cnt   <= '0;
            pat_act     <= PAT_XOR;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            hc          <= '0;
            vc          <= '0;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            hc <= h_wrap ? '0 : hc + CNT_W'(1);
            if (h_wrap) begin
                vc <= v_wrap ? '0 : vc + CNT_W'(1);
            end
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (origin) begin
                pat_act <= pat_cur;
            end
            de          <= de_c;
            hs          <= hs_on ? HS_POL : ~HS_POL;
            vs          <= vs_on ? VS_POL : ~VS_POL;
            x           <= hc;
            y           <= vc;
            red         <= de_c ? pat_r : '0;
            green       <= de_c ? pat_g : '0;
            blue        <= de_c ? pat_b : '0;
            frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: pixel table, timing/corner sequences,
// and a randomized run against a raster-index reference model.
module tb_video_timing_gen;

    localparam int HA  = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA  = 4,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic          hs, vs, de, frame_start;
    logic [11:0]   x, y;
    logic [CW-1:0] red, green, blue;
    logic [7:0]    frame_cnt;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .x           (x),
        .y           (y),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic [5:0]  r;
        logic [5:0]  g;
        logic [5:0]  b;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int pat;
        int px;
        int py;
        int r;
        int g;
        int b;
    } vec_t;

    obs_t exp_o;
    obs_t act_o;
    assign act_o = {hs, vs, de, x, y, red, green, blue, frame_start, frame_cnt};

    int compared = 0;
    int mismatched = 0;
    bit sb_on = 1'b0;
    int m_p, m_f, m_pat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference colour straight from the pattern definitions.
    function automatic logic [17:0] colour(input int pat, input int px, input int py, input int f);
        int v6, r, g, b, bar;
        r = 0; g = 0; b = 0;
        case (pat)
            0: begin
                v6 = ((py + f) % 64) ^ ((px + f) % 64);
                r = (v6 * 2) % 64; g = (v6 * 4) % 64; b = (v6 * 3) % 64;
            end
            1: begin
                bar = px / (HA / 8);
                case (bar)
                    0: begin r = 63; g = 63; b = 63; end
                    1: begin r = 63; g = 63; b = 0;  end
                    2: begin r = 0;  g = 63; b = 63; end
                    3: begin r = 0;  g = 63; b = 0;  end
                    4: begin r = 63; g = 0;  b = 63; end
                    5: begin r = 63; g = 0;  b = 0;  end
                    6: begin r = 0;  g = 0;  b = 63; end
                    default: begin r = 0; g = 0; b = 0; end
                endcase
            end
            2: if (px % 32 == 0 || py % 32 == 0) begin r = 63; g = 63; b = 63; end
            default: begin r = 32; g = 32; b = 32; end
        endcase
`ifdef VTG_BORDER_EN
        if (px < 3 || px >= HA - 3 || py < 3 || py >= VA - 3) begin r = 63; g = 0; b = 0; end
`endif
        return {r[5:0], g[5:0], b[5:0]};
    endfunction

    function automatic obs_t idle_obs(input int f);
        obs_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        o.fc = 8'(f);
        return o;
    endfunction

    // Output for raster index p (0..FT-1) of frame f using pattern pat.
    function automatic obs_t pix_obs(input int p, input int f, input int pat);
        obs_t o;
        int h, v;
        h    = p % HT;
        v    = p / HT;
        o    = '0;
        o.de = (h < HA) && (v < VA);
        o.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
        o.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
        o.x  = 12'(h);
        o.y  = 12'(v);
        o.fs = (p == 0);
        if (o.de) {o.r, o.g, o.b} = colour(pat, h, v, f);
        o.fc = 8'((p == FT - 1) ? (f + 1) % 256 : f);
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p   <= 0;
            m_f   <= 0;
            m_pat <= 0;
            exp_o <= idle_obs(0);
        end else if (!enable) begin
            m_p   <= 0;
            exp_o <= idle_obs(m_f);
        end else begin
            exp_o <= pix_obs(m_p, m_f, (m_p == 0) ? int'(pattern_sel) : m_pat);
            if (m_p == 0) m_pat <= int'(pattern_sel);
            m_p <= (m_p + 1) % FT;
            if (m_p == FT - 1) m_f <= (m_f + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (sb_on) check("scoreboard", act_o, exp_o);
    end

    task automatic restart(input int pat);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        pattern_sel = 2'(pat);
        enable      = 1'b1;
        @(negedge clk);
        rst_n       = 1'b1;
    endtask

    task automatic goto_pixel(input int px, input int py, output bit found);
        found = 1'b0;
        for (int k = 0; k < FT + 4 && !found; k++) begin
            @(negedge clk);
            if (exp_o.de && int'(exp_o.x) == px && int'(exp_o.y) == py) found = 1'b1;
        end
    endtask

    vec_t vecs [14];
    bit   found;
    int   de_n, hs_lo, vs_lo, fs_n, first_hs, blank_bad, gap_bad, gap;
    bit   fs192;
    int   fc0, fc191, fc383;
    int   er, eg, eb;

    initial begin
        vecs = '{
            '{1, 0, 0, 63, 63, 63}, '{1, 1, 2, 63, 63, 63}, '{1, 2, 0, 63, 63, 0},
            '{1, 4, 1, 0, 63, 63},  '{1, 10, 3, 63, 0, 0},  '{1, 14, 0, 0, 0, 0},
            '{1, 15, 3, 0, 0, 0},   '{0, 3, 1, 4, 8, 6},    '{0, 5, 2, 14, 28, 21},
            '{0, 6, 3, 10, 20, 15}, '{2, 0, 0, 63, 63, 63}, '{2, 1, 1, 0, 0, 0},
            '{2, 7, 0, 63, 63, 63}, '{3, 8, 2, 32, 32, 32}
        };

        #1 rst_n = 1'b0;
        #2;
        check("reset_state", act_o, idle_obs(0));
        sb_on = 1'b1;

        // Pixel table, each taken in the first frame after reset.
        foreach (vecs[i]) begin
            restart(vecs[i].pat);
            goto_pixel(vecs[i].px, vecs[i].py, found);
            er = vecs[i].r; eg = vecs[i].g; eb = vecs[i].b;
`ifdef VTG_BORDER_EN
            er = 63; eg = 0; eb = 0;
`endif
            check("pixel_found", found, 1'b1);
            check($sformatf("pixel_rgb[%0d]", i), {red, green, blue}, {6'(er), 6'(eg), 6'(eb)});
        end

        // Two frames of timing.
        restart(1);
        @(negedge clk);
        check("first_frame_start", frame_start, 1'b1);
        de_n = 0; hs_lo = 0; vs_lo = 0; fs_n = 0; first_hs = -1; blank_bad = 0; fs192 = 1'b0;
        fc0 = -1; fc191 = -1; fc383 = -1;
        for (int c = 0; c < 2 * FT; c++) begin
            if (c > 0) @(negedge clk);
            if (de) de_n++;
            if (!hs) begin
                hs_lo++;
                if (first_hs < 0) first_hs = c;
            end
            if (!vs) vs_lo++;
            if (!de && (red != 0 || green != 0 || blue != 0)) blank_bad++;
            if (frame_start) begin
                fs_n++;
                if (c == FT) fs192 = 1'b1;
            end
            if (c == 0) fc0 = int'(frame_cnt);
            if (c == FT - 1) fc191 = int'(frame_cnt);
            if (c == 2 * FT - 1) fc383 = int'(frame_cnt);
        end
        check("de_cycles", de_n, 128);
        check("hs_low_cycles", hs_lo, 48);
        check("hs_first_low", first_hs, 18);
        check("vs_low_cycles", vs_lo, 96);
        check("blank_rgb_zero", blank_bad, 0);
        check("frame_start_count", fs_n, 2);
        check("frame_start_period", fs192, 1'b1);
        check("frame_cnt_0", fc0, 0);
        check("frame_cnt_1", fc191, 1);
        check("frame_cnt_2", fc383, 2);

        // Pattern change mid-frame takes effect only at the next origin.
        restart(0);
        for (int c = 0; c <= FT; c++) begin
            @(negedge clk);
            if (c == 28) pattern_sel = 2'd2;
            if (c == 51) check("switch_still_xor", {red, green, blue}, {6'd2, 6'd4, 6'd3});
            if (c == FT) check("switch_grid_origin", {frame_start, red, green, blue}, {1'b1, 6'd63, 6'd63, 6'd63});
        end

        // Enable gap in line 2.
        restart(3);
        for (int c = 0; c <= 53; c++) @(negedge clk);
        enable  = 1'b0;
        gap_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (de || frame_start || !hs || !vs || red != 0) gap_bad++;
        end
        check("gap_outputs_idle", gap_bad, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_origin", {frame_start, de, x, y, frame_cnt}, {1'b1, 1'b1, 12'd0, 12'd0, 8'd0});

        // Asynchronous reset mid-frame.
        restart(2);
        for (int c = 0; c < FT + 60; c++) @(negedge clk);
        check("frame_cnt_before_reset", frame_cnt, 8'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", act_o, idle_obs(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_origin", {frame_start, x, y, frame_cnt}, {1'b1, 12'd0, 12'd0, 8'd0});

        // Randomized run: enable gaps, pattern changes, occasional resets.
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (gap > 0) begin
                gap--;
                enable = 1'b0;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 299) == 0) gap = int'($urandom_range(1, 12));
            end
            if ($urandom_range(0, 29) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        sb_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
